// File: rtl/dap_bit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : dap_bit_shifter
// Description : Single-line serial bit shifter for a debug access port.
//               It shifts 1..32 bits out (write) or in (read), paced by
//               strobes from an external baud generator. The drive-moment
//               strobe is sclk_pulse and the sample-moment strobe is
//               sclk_delay_pulse.
//
//               Optional feature macro: DAP_SHIFTER_PARITY_EN
//                 defined   : an even-parity bit follows the data bits
//                             (PAR state). On a read, parity_err reports
//                             a parity mismatch.
//                 undefined : no parity bit, and parity_err is tied to 0.
//
// Parameters  : LSB_FIRST  1 = bit 0 goes first, 0 = bit len_m1 goes first
//
// Ports       : clk              system clock, rising edge
//               reset            synchronous active-high reset
//               sclk_pulse       drive-moment strobe (1 cycle)
//               sclk_delay_pulse sample-moment strobe (1 cycle)
//               start            transfer request, accepted only in IDLE
//               dir              1 = write (drive line), 0 = read
//               len_m1[4:0]      bit count minus one
//               tx_data[31:0]    write data, right-justified
//               io_in            sampled line level
//               io_out           driven line level
//               io_oe            line output enable
//               busy             transfer in progress
//               done             one-cycle completion pulse
//               rx_data[31:0]    read result, right-justified
//               parity_err       read parity mismatch
//
// Revision    : 1.0  initial release
// ============================================================================
module dap_bit_shifter #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk_pulse,
    input  logic        sclk_delay_pulse,
    input  logic        start,
    input  logic        dir,
    input  logic [4:0]  len_m1,
    input  logic [31:0] tx_data,
    input  logic        io_in,
    output logic        io_out,
    output logic        io_oe,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        parity_err
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARM   = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
`ifdef DAP_SHIFTER_PARITY_EN
    localparam logic [2:0] c_ST_PAR   = 3'd3;
`endif
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    // State entered once the last data bit has been driven or sampled.
`ifdef DAP_SHIFTER_PARITY_EN
    localparam logic [2:0] c_ST_POST  = c_ST_PAR;
`else
    localparam logic [2:0] c_ST_POST  = c_ST_HOLD;
`endif

    localparam bit c_LSB = (LSB_FIRST != 0);

    logic [2:0]  r_state;
    logic        r_dir;
    logic [4:0]  r_len;
    logic [31:0] r_sh;
    logic [5:0]  r_cnt;
    logic        r_io_out;
    logic        r_io_oe;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_rx;
`ifdef DAP_SHIFTER_PARITY_EN
    logic        r_par;
    logic        r_par_err;
`endif

    logic        w_last;
    logic        w_bit_out;
    logic [31:0] w_sh_out;
    logic [31:0] w_sh_in;
    logic [31:0] w_load;

    // The counter is 6 bits wide, so a 32-bit transfer ends at 31 and never wraps.
    assign w_last    = (r_cnt == {1'b0, r_len});

    // A write shifts the bit being driven out of one end of r_sh. A read
    // shifts the sampled bit in at the opposite end.
    assign w_bit_out = c_LSB ? r_sh[0] : r_sh[31];
    assign w_sh_out  = c_LSB ? {1'b0, r_sh[31:1]} : {r_sh[30:0], 1'b0};
    assign w_sh_in   = c_LSB ? {io_in, r_sh[31:1]} : {r_sh[30:0], io_in};

    // For MSB-first, bit len_m1 is pre-aligned to bit 31. The upper unused
    // bits are shifted away by this alignment.
    assign w_load    = c_LSB ? tx_data : (tx_data << (~len_m1));

    // LSB-first reads fill r_sh from the top, so the result is shifted down
    // by 31-len (equal to ~len in 5 bits). MSB-first reads fill r_sh from
    // a zero register, so they are already right-justified.
    function automatic logic [31:0] f_justify(input logic [31:0] v, input logic [4:0] len);
        if (c_LSB) begin
            return v >> (~len);
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_dir     <= 1'b0;
            r_len     <= 5'd0;
            r_sh      <= 32'd0;
            r_cnt     <= 6'd0;
            r_io_out  <= 1'b0;
            r_io_oe   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx      <= 32'd0;
`ifdef DAP_SHIFTER_PARITY_EN
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A write returns to IDLE in its done cycle, so a start
                    // seen in that cycle is blocked here.
                    if (start && !r_done) begin
                        r_dir   <= dir;
                        r_len   <= len_m1;
                        r_sh    <= dir ? w_load : 32'd0;
                        r_cnt   <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_ARM;
`ifdef DAP_SHIFTER_PARITY_EN
                        r_par   <= ^(tx_data & (32'hFFFF_FFFF >> (~len_m1)));
`endif
                    end
                end

                c_ST_ARM, c_ST_SHIFT: begin
                    if (r_dir) begin
                        if (sclk_pulse) begin
                            r_io_out <= w_bit_out;
                            r_io_oe  <= 1'b1;
                            r_sh     <= w_sh_out;
                            if (w_last) begin
                                r_state <= c_ST_POST;
                            end else begin
                                r_cnt   <= r_cnt + 6'd1;
                                r_state <= c_ST_SHIFT;
                            end
                        end
                    end else if ((r_state == c_ST_SHIFT) || sclk_pulse) begin
                        // In ARM, sampling opens with the arming pulse. A
                        // sample strobe in the same cycle already counts.
                        r_state <= c_ST_SHIFT;
                        if (sclk_delay_pulse) begin
                            r_sh <= w_sh_in;
                            if (w_last) begin
`ifdef DAP_SHIFTER_PARITY_EN
                                r_state <= c_ST_PAR;
`else
                                r_state <= c_ST_HOLD;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_rx    <= f_justify(w_sh_in, r_len);
`endif
                            end else begin
                                r_cnt <= r_cnt + 6'd1;
                            end
                        end
                    end
                end

`ifdef DAP_SHIFTER_PARITY_EN
                c_ST_PAR: begin
                    if (r_dir) begin
                        if (sclk_pulse) begin
                            r_io_out <= r_par;
                            r_state  <= c_ST_HOLD;
                        end
                    end else if (sclk_delay_pulse) begin
                        // Unused r_sh bits are zero, so XOR over all of
                        // r_sh equals XOR over the received data bits.
                        r_par_err <= io_in ^ (^r_sh);
                        r_rx      <= f_justify(r_sh, r_len);
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= c_ST_HOLD;
                    end
                end
`endif

                c_ST_HOLD: begin
                    if (r_dir) begin
                        // The last bit stays on the line for one more bit time.
                        if (sclk_pulse) begin
                            r_io_oe <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        // A read is already complete. This cycle is its done cycle.
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign io_out  = r_io_out;
    assign io_oe   = r_io_oe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx;
`ifdef DAP_SHIFTER_PARITY_EN
    assign parity_err = r_par_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dap_bit_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dap_bit_shifter
// Description : Directed self-checking bench for dap_bit_shifter
//               (LSB_FIRST = 1). Honors DAP_SHIFTER_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dap_bit_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk_pulse;
    logic        sclk_delay_pulse;
    logic        start;
    logic        dir;
    logic [4:0]  len_m1;
    logic [31:0] tx_data;
    logic        io_in;
    wire         io_out;
    wire         io_oe;
    wire         busy;
    wire         done;
    wire  [31:0] rx_data;
    wire         parity_err;

    int n_checks = 0;
    int n_errors = 0;

    logic wr_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic rd_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    dap_bit_shifter #(.LSB_FIRST(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .sclk_pulse       (sclk_pulse),
        .sclk_delay_pulse (sclk_delay_pulse),
        .start            (start),
        .dir              (dir),
        .len_m1           (len_m1),
        .tx_data          (tx_data),
        .io_in            (io_in),
        .io_out           (io_out),
        .io_oe            (io_oe),
        .busy             (busy),
        .done             (done),
        .rx_data          (rx_data),
        .parity_err       (parity_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic p, input logic d, input logic din);
        sclk_pulse       = p;
        sclk_delay_pulse = d;
        io_in            = din;
        tick();
        sclk_pulse       = 1'b0;
        sclk_delay_pulse = 1'b0;
    endtask

    task automatic start_xfer(input logic d, input logic [4:0] l, input logic [31:0] t);
        dir     = d;
        len_m1  = l;
        tx_data = t;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sclk_pulse = 1'b0; sclk_delay_pulse = 1'b0;
        start = 1'b0; dir = 1'b0; len_m1 = 5'd0; tx_data = 32'd0; io_in = 1'b0;
        tick(); tick();
        check("rst_io_oe", io_oe, 0);
        check("rst_io_out", io_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_parity_err", parity_err, 0);
        reset = 1'b0;
        tick();

        // Write 0xA5, 8 bits. A change to tx_data after start must not matter.
        start_xfer(1'b1, 5'd7, 32'h0000_00A5);
        check("wr_busy_after_start", busy, 1);
        check("wr_oe_before_arm", io_oe, 0);
        tx_data = 32'hFFFF_0000;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) start = 1'b1;
            strobe(1'b1, 1'b0, 1'b0);
            start = 1'b0;
            check($sformatf("wr_bit%0d", i), io_out, wr_seq[i]);
            check($sformatf("wr_oe%0d", i), io_oe, 1);
            tick(); tick();
            check($sformatf("wr_nodone%0d", i), done, 0);
        end
`ifdef DAP_SHIFTER_PARITY_EN
        strobe(1'b1, 1'b0, 1'b0);
        check("wr_parity_bit", io_out, 0);
        check("wr_parity_nodone", done, 0);
`endif
        strobe(1'b1, 1'b0, 1'b0);
        check("wr_done", done, 1);
        check("wr_oe_released", io_oe, 0);
`ifdef DAP_SHIFTER_PARITY_EN
        check("wr_out_hold", io_out, 0);
`else
        check("wr_out_hold", io_out, 1);
`endif
        check("wr_rx_untouched", rx_data, 0);
        // A start in the done cycle must be ignored.
        dir = 1'b1; len_m1 = 5'd0; tx_data = 32'h1; start = 1'b1;
        tick();
        start = 1'b0;
        check("wr_done_single", done, 0);
        check("wr_start_in_done_ignored", busy, 0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        check("wr_idle_oe", io_oe, 0);
        check("wr_idle_done", done, 0);

        // Read 4 bits, 1,1,0,1. A sample strobe before the arming pulse is ignored.
        start_xfer(1'b0, 5'd3, 32'd0);
        check("rd_busy", busy, 1);
        strobe(1'b0, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) check($sformatf("rd_nodone%0d", i), done, 0);
            strobe(1'b0, 1'b1, rd_seq[i]);
            check($sformatf("rd_oe%0d", i), io_oe, 0);
        end
`ifdef DAP_SHIFTER_PARITY_EN
        check("rd_nodone_before_par", done, 0);
        strobe(1'b0, 1'b1, 1'b1);
`endif
        check("rd_done", done, 1);
        check("rd_rx_0xB", rx_data, 32'h0000_000B);
        check("rd_busy_cleared", busy, 0);
        check("rd_parity_ok", parity_err, 0);
        tick();
        check("rd_done_single", done, 0);
        check("rd_rx_held", rx_data, 32'h0000_000B);

        // Read 32 bits with coincident strobes, alternating data starting at 1.
        start_xfer(1'b0, 5'd31, 32'd0);
        for (int i = 0; i < 32; i++) begin
            strobe(1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
            if (i == 30) check("rd32_nodone_at31", done, 0);
        end
`ifdef DAP_SHIFTER_PARITY_EN
        strobe(1'b1, 1'b1, 1'b0);
`endif
        check("rd32_done", done, 1);
        check("rd32_rx", rx_data, 32'h5555_5555);
        check("rd32_oe", io_oe, 0);
        tick();

`ifdef DAP_SHIFTER_PARITY_EN
        // Data 0x03 with parity bit 1 sets parity_err. Parity bit 0 clears it.
        for (int p = 1; p >= 0; p--) begin
            start_xfer(1'b0, 5'd7, 32'd0);
            strobe(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) strobe(1'b0, 1'b1, (i < 2) ? 1'b1 : 1'b0);
            strobe(1'b0, 1'b1, p[0]);
            check($sformatf("par_done_p%0d", p), done, 1);
            check($sformatf("par_err_p%0d", p), parity_err, p[0]);
            check($sformatf("par_rx_p%0d", p), rx_data, 32'h3);
            tick();
        end
        start_xfer(1'b0, 5'd31, 32'd0);
        for (int i = 0; i < 33; i++) strobe(1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
        tick();
`endif

        // A 1-bit write must leave rx_data unchanged.
        start_xfer(1'b1, 5'd0, 32'h1);
        strobe(1'b1, 1'b0, 1'b0);
        check("wr1_bit", io_out, 1);
        check("wr1_oe", io_oe, 1);
`ifdef DAP_SHIFTER_PARITY_EN
        strobe(1'b1, 1'b0, 1'b0);
`endif
        strobe(1'b1, 1'b0, 1'b0);
        check("wr1_done", done, 1);
        check("wr1_rx_kept", rx_data, 32'h5555_5555);
        tick();

        // Reset after bit 3 of a 32-bit write.
        start_xfer(1'b1, 5'd31, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b0);
        check("rstx_oe_before", io_oe, 1);
        check("rstx_out_before", io_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstx_oe", io_oe, 0);
        check("rstx_busy", busy, 0);
        check("rstx_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1'b0, 1'b0);
            check($sformatf("rstx_nodone%0d", i), done, 0);
        end
        start_xfer(1'b1, 5'd0, 32'h1);
        check("rstx_restart_busy", busy, 1);
        strobe(1'b1, 1'b0, 1'b0);
        check("rstx_restart_bit", io_out, 1);
`ifdef DAP_SHIFTER_PARITY_EN
        strobe(1'b1, 1'b0, 1'b0);
`endif
        strobe(1'b1, 1'b0, 1'b0);
        check("rstx_restart_done", done, 1);
        check("rstx_restart_oe", io_oe, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
